// File: rtl/cpu_core.sv
// 8-bit two-cycle (fetch/execute) RISC core: four registers, 4-bit PC, and a shared
// 16-word memory that reads combinationally and writes synchronously.
module cpu_core (
  input  logic       clk,
  input  logic       clr,
  output logic       read,
  output logic       write,
  input  logic [7:0] memoryOut,
  output logic [7:0] memoryIn,
  output logic [3:0] address
);

  typedef enum logic {StFetch, StExec} state_e;

  state_e          state_q, state_d;
  logic [3:0]      pc_q, pc_d;
  logic [7:0]      ir_q, ir_d;
  logic [3:0][7:0] regs_q, regs_d;

  logic [1:0] op, sel_hi, sel_rs, fn;
  logic [3:0] imm_addr;
  logic [7:0] rd_val, rs_val;

  assign op       = ir_q[7:6];
  assign sel_hi   = ir_q[5:4];
  assign sel_rs   = ir_q[3:2];
  assign fn       = ir_q[1:0];
  assign imm_addr = ir_q[3:0];
  assign rd_val   = regs_q[sel_hi];
  assign rs_val   = regs_q[sel_rs];

  // Store data always follows IR[5:4]; it only matters while write is high.
  assign memoryIn = rd_val;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= StFetch;
      pc_q    <= 4'h0;
      ir_q    <= 8'h00;
      regs_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      regs_q  <= regs_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    regs_d  = regs_q;
    address = pc_q;
    read    = 1'b0;
    write   = 1'b0;

    unique case (state_q)
      StFetch: begin
        read    = 1'b1;
        ir_d    = memoryOut;
        pc_d    = pc_q + 4'd1;
        state_d = StExec;
      end
      StExec: begin
        state_d = StFetch;
        unique case (op)
          2'b00: begin
            address        = imm_addr;
            read           = 1'b1;
            regs_d[sel_hi] = memoryOut;
          end
          2'b01: begin
            unique case (fn)
              2'b00: regs_d[sel_hi] = {1'b0, rs_val[7:1]};
              2'b01: regs_d[sel_hi] = rd_val + rs_val;
              2'b10: regs_d[sel_hi] = rd_val - rs_val;
              2'b11: regs_d[sel_hi] = rd_val & rs_val;
            endcase
          end
          2'b10: begin
            address = imm_addr;
            write   = 1'b1;
          end
          2'b11: begin
            if (rd_val == 8'h00) begin
              pc_d = imm_addr;
            end
          end
        endcase
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_core.sv
// Directed bench for cpu_core: behavioural memory, hand-computed expected values,
// immediate assertions at every comparison.
module tb_cpu_core;

  logic       clk;
  logic       clr;
  logic       read;
  logic       write;
  logic [7:0] memoryOut;
  logic [7:0] memoryIn;
  logic [3:0] address;

  logic [7:0] mem      [16];
  logic [7:0] init_mem [16];
  logic [7:0] exp_mem  [16];

  int checks;
  int passes;
  int fails;

  cpu_core dut (
    .clk       (clk),
    .clr       (clr),
    .read      (read),
    .write     (write),
    .memoryOut (memoryOut),
    .memoryIn  (memoryIn),
    .address   (address)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory reloads its image on every clock edge seen while clr is high.
  always_ff @(posedge clk) begin
    if (clr) begin
      mem <= init_mem;
    end else if (write) begin
      mem[address] <= memoryIn;
    end
  end

  assign memoryOut = mem[address];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_image();
    for (int i = 0; i < 16; i++) init_mem[i] = 8'h00;
  endtask

  // Reset for one edge so memory picks up the image, then release just after it.
  task automatic do_reset();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    fails  = 0;
    clr    = 1'b1;
    clear_image();

    // Reset state while clr is held
    tick(1);
    chk("rst_address", {4'h0, address}, 8'h00);
    chk("rst_read", {7'h0, read}, 8'h01);
    chk("rst_write", {7'h0, write}, 8'h00);
    chk("rst_memin", memoryIn, 8'h00);
    chk("rst_pc", {4'h0, dut.pc_q}, 8'h00);
    chk("rst_ir", dut.ir_q, 8'h00);
    for (int r = 0; r < 4; r++) chk($sformatf("rst_r%0d", r), dut.regs_q[r], 8'h00);

    // LOAD then SHR chain on R3
    clear_image();
    init_mem[0] = 8'h37;
    init_mem[1] = 8'h7C;
    init_mem[2] = 8'h7C;
    init_mem[7] = 8'h06;
    do_reset();
    tick(1);
    chk("load_address", {4'h0, address}, 8'h07);
    chk("load_read", {7'h0, read}, 8'h01);
    chk("load_write", {7'h0, write}, 8'h00);
    tick(1);
    chk("load_r3", dut.regs_q[3], 8'h06);
    chk("load_pc", {4'h0, dut.pc_q}, 8'h01);
    chk("fetch1_address", {4'h0, address}, 8'h01);
    tick(1);
    chk("alu_read", {7'h0, read}, 8'h00);
    chk("alu_write", {7'h0, write}, 8'h00);
    tick(1);
    chk("shr1_r3", dut.regs_q[3], 8'h03);
    tick(2);
    chk("shr2_r3", dut.regs_q[3], 8'h01);

    // ADD / SUB wrap on R2 with R3
    clear_image();
    init_mem[0]  = 8'h2E;
    init_mem[1]  = 8'h3F;
    init_mem[2]  = 8'h6D;
    init_mem[3]  = 8'h6E;
    init_mem[14] = 8'hFF;
    init_mem[15] = 8'h02;
    do_reset();
    tick(4);
    chk("ld_r2", dut.regs_q[2], 8'hFF);
    chk("ld_r3", dut.regs_q[3], 8'h02);
    tick(2);
    chk("add_wrap_r2", dut.regs_q[2], 8'h01);
    tick(2);
    chk("sub_wrap_r2", dut.regs_q[2], 8'hFF);
    chk("sub_r3_kept", dut.regs_q[3], 8'h02);

    // STORE R3 to address 14
    clear_image();
    init_mem[0] = 8'h37;
    init_mem[1] = 8'hBE;
    init_mem[7] = 8'h06;
    exp_mem = init_mem;
    exp_mem[14] = 8'h06;
    do_reset();
    tick(3);
    chk("st_write", {7'h0, write}, 8'h01);
    chk("st_read", {7'h0, read}, 8'h00);
    chk("st_address", {4'h0, address}, 8'h0E);
    chk("st_memin", memoryIn, 8'h06);
    tick(1);
    chk("st_write_drop", {7'h0, write}, 8'h00);
    for (int i = 0; i < 16; i++) chk($sformatf("st_mem%0d", i), mem[i], exp_mem[i]);

    // Reset arriving mid-STORE aborts it asynchronously
    do_reset();
    tick(3);
    chk("abort_pre_write", {7'h0, write}, 8'h01);
    clr = 1'b1;
    #1;
    chk("abort_write", {7'h0, write}, 8'h00);
    chk("abort_address", {4'h0, address}, 8'h00);
    chk("abort_read", {7'h0, read}, 8'h01);
    chk("abort_r3", dut.regs_q[3], 8'h00);
    tick(1);
    clr = 1'b0;

    // JZ taken, JZ not taken, and PC wrap from 15
    clear_image();
    init_mem[0]  = 8'h1F;
    init_mem[1]  = 8'hC5;
    init_mem[5]  = 8'hD5;
    init_mem[6]  = 8'hCF;
    init_mem[15] = 8'h03;
    do_reset();
    tick(2);
    chk("jz_r1", dut.regs_q[1], 8'h03);
    tick(2);
    chk("jz_taken_pc", {4'h0, address}, 8'h05);
    tick(2);
    chk("jz_fall_pc", {4'h0, address}, 8'h06);
    tick(2);
    chk("jz_to15_pc", {4'h0, address}, 8'h0F);
    tick(2);
    chk("wrap_pc", {4'h0, address}, 8'h00);
    chk("wrap_read", {7'h0, read}, 8'h01);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
